vector_lane_packer: RTL and testbench

- Sequential controller for the `mov_vector` lane-insert datapath.
- Accepts a stream of N-bit scalars over a valid/ready handshake and inserts each into the next 32-bit lane of a 128-bit accumulator, starting from a caller-supplied base vector.
- Presents the assembled vector on a valid/ready output port.
- Sits between the scalar register file / ALU writeback and the vector register file write port.

---
 rtl/vector_lane_packer_pkg.sv | 8 +
 rtl/vector_lane_packer_if.sv | 22 ++
 rtl/vector_lane_packer_mov_vector.sv | 15 +
 rtl/vector_lane_packer.sv | 64 ++++++
 tb/tb_vector_lane_packer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/vector_lane_packer_pkg.sv
// vec_pkg: shared widths, FSM state and lane index types for the lane packer
package vec_pkg;
  localparam int V_W = 128;
  localparam int S_W = 32;
  localparam int LANES = V_W / S_W;
  typedef enum logic [1:0] {IDLE, FILL, OUT} pack_state_t;
  typedef logic [1:0] lane_idx_t;
endpackage

// File: rtl/vector_lane_packer_if.sv
// vector_lane_packer_if: control, scalar-in and vector-out bundle of the lane packer
interface vector_lane_packer_if;
  logic start;
  logic [vec_pkg::V_W-1:0] base_vec;
  logic flush;
  logic s_valid;
  logic s_ready;
  logic [vec_pkg::S_W-1:0] s_data;
  logic m_valid;
  logic m_ready;
  logic [vec_pkg::V_W-1:0] m_data;
  logic [2:0] m_lanes;
  logic busy;
  modport master (
    output start, base_vec, flush, s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_lanes, busy
  );
  modport slave (
    input  start, base_vec, flush, s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_lanes, busy
  );
endinterface

// File: rtl/vector_lane_packer_mov_vector.sv
// mov_vector: replace lane imm of vector_input with src, all other lanes pass through
module mov_vector #(
  parameter int V = 128,
  parameter int N = 32
) (
  input  logic [N-1:0]             src,
  input  logic [V-1:0]             vector_input,
  input  logic [$clog2(V/N)-1:0]   imm,
  output logic [V-1:0]             dst
);
  always_comb begin
    dst = vector_input;
    dst[imm*N +: N] = src;
  end
endmodule

// File: rtl/vector_lane_packer.sv
// vector_lane_packer: packs up to four 32-bit scalars into lanes of a 128-bit base vector
module vector_lane_packer
  import vec_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  vector_lane_packer_if.slave   bus_io
);
  pack_state_t state_q, state_d;
  logic [V_W-1:0] acc_q, acc_d, ins;
  lane_idx_t lane_q, lane_d;
  logic [2:0] cnt_q, cnt_d;
  logic beat;
  mov_vector #(.V(V_W), .N(S_W)) u_mov (
    .src          (bus_io.s_data),
    .vector_input (acc_q),
    .imm          (lane_q),
    .dst          (ins)
  );
  assign beat = (state_q == FILL) && bus_io.s_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (bus_io.start) begin
        acc_d   = bus_io.base_vec;
        lane_d  = '0;
        cnt_d   = '0;
        state_d = FILL;
      end
      FILL: begin
        if (beat) begin
          acc_d  = ins;
          lane_d = lane_q + 2'd1;
          cnt_d  = cnt_q + 3'd1;
        end
        // a beat riding with flush is inserted before the pack closes
        if ((beat && lane_q == 2'd3) || bus_io.flush) state_d = OUT;
      end
      OUT: state_d = bus_io.m_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  assign bus_io.s_ready = state_q == FILL;
  assign bus_io.m_valid = state_q == OUT;
  assign bus_io.busy    = state_q != IDLE;
  assign bus_io.m_data  = acc_q;
  assign bus_io.m_lanes = cnt_q;
endmodule

// File: tb/tb_vector_lane_packer.sv
// tb_vector_lane_packer: directed and scoreboard checks of the lane packer
module tb_vector_lane_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  vector_lane_packer_if bus ();
  vector_lane_packer dut (.clk(clk), .rst(rst), .bus_io(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start_pack(input logic [127:0] base);
    bus.start = 1'b1;
    bus.base_vec = base;
    step();
    bus.start = 1'b0;
  endtask
  task automatic send_beat(input logic [31:0] d, input logic fl);
    bus.s_valid = 1'b1;
    bus.s_data = d;
    bus.flush = fl;
    step();
    bus.s_valid = 1'b0;
    bus.flush = 1'b0;
  endtask
  task automatic flush_only();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask
  task automatic take_out();
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
  endtask
  task automatic test_reset();
    logic [5:0] o;
    #3;
    o = {bus.s_ready, bus.m_valid, bus.busy, |bus.m_data, |bus.m_lanes, 1'b0};
    tests++;
    if (o !== 6'b0) begin fails++; $display("FAIL reset_initial: got %b expected 000000", o); end
    step();
    rst = 1'b0;
    start_pack({4{32'hCCCCCCCC}});
    send_beat(32'hDEAD0001, 1'b0);
    send_beat(32'hDEAD0002, 1'b0);
    tests++;
    if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL reset_prefill: s_ready got %b expected 1", bus.s_ready); end
    #2 rst = 1'b1;
    #1;
    o = {bus.s_ready, bus.m_valid, bus.busy, |bus.m_data, |bus.m_lanes, 1'b0};
    tests++;
    if (o !== 6'b0) begin fails++; $display("FAIL reset_midfill: got %b expected 000000", o); end
    step();
    rst = 1'b0;
    start_pack('0);
    send_beat(32'h5, 1'b0);
    send_beat(32'h6, 1'b0);
    send_beat(32'h7, 1'b0);
    send_beat(32'h8, 1'b0);
    tests++;
    if (bus.m_data !== {32'h8, 32'h7, 32'h6, 32'h5} || bus.m_lanes !== 3'd4)
      begin fails++; $display("FAIL reset_repack: got %h/%0d expected %h/4", bus.m_data, bus.m_lanes, {32'h8, 32'h7, 32'h6, 32'h5}); end
    take_out();
  endtask
  task automatic test_full_pack();
    start_pack({4{32'hFFFFFFFF}});
    tests++;
    if (bus.s_ready !== 1'b1 || bus.busy !== 1'b1) begin fails++; $display("FAIL full_start: s_ready %b busy %b expected 1 1", bus.s_ready, bus.busy); end
    send_beat(32'h11111111, 1'b0);
    send_beat(32'h22222222, 1'b0);
    send_beat(32'h33333333, 1'b0);
    tests++;
    if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL full_early_valid: got %b expected 0", bus.m_valid); end
    send_beat(32'h44444444, 1'b0);
    tests++;
    if (bus.m_valid !== 1'b1 || bus.s_ready !== 1'b0) begin fails++; $display("FAIL full_valid: m_valid %b s_ready %b expected 1 0", bus.m_valid, bus.s_ready); end
    tests++;
    if (bus.m_data !== 128'h44444444_33333333_22222222_11111111 || bus.m_lanes !== 3'd4)
      begin fails++; $display("FAIL full_data: got %h/%0d expected 44444444333333332222222211111111/4", bus.m_data, bus.m_lanes); end
    take_out();
    tests++;
    if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin fails++; $display("FAIL full_idle: busy %b m_valid %b expected 0 0", bus.busy, bus.m_valid); end
  endtask
  task automatic test_early_flush();
    start_pack({4{32'hAAAAAAAA}});
    send_beat(32'h1, 1'b0);
    send_beat(32'h2, 1'b0);
    flush_only();
    tests++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== {32'hAAAAAAAA, 32'hAAAAAAAA, 32'h2, 32'h1} || bus.m_lanes !== 3'd2)
      begin fails++; $display("FAIL early_flush: got %b %h/%0d expected 1 aaaaaaaaaaaaaaaa0000000200000001/2", bus.m_valid, bus.m_data, bus.m_lanes); end
    take_out();
  endtask
  task automatic test_flush_with_beat();
    logic [127:0] b;
    start_pack({4{32'hBBBBBBBB}});
    send_beat(32'h1, 1'b0);
    send_beat(32'h2, 1'b0);
    send_beat(32'h3, 1'b1);
    tests++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== {32'hBBBBBBBB, 32'h3, 32'h2, 32'h1} || bus.m_lanes !== 3'd3)
      begin fails++; $display("FAIL flush_beat: got %b %h/%0d expected 1 bbbbbbbb000000030000000200000001/3", bus.m_valid, bus.m_data, bus.m_lanes); end
    take_out();
    b = 128'h0123456789ABCDEF_FEDCBA9876543210;
    start_pack(b);
    flush_only();
    tests++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== b || bus.m_lanes !== 3'd0)
      begin fails++; $display("FAIL flush_empty: got %b %h/%0d expected 1 %h/0", bus.m_valid, bus.m_data, bus.m_lanes, b); end
    take_out();
  endtask
  task automatic test_backpressure();
    logic [127:0] e;
    e = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    start_pack('0);
    send_beat(32'hA1, 1'b0);
    send_beat(32'hA2, 1'b0);
    send_beat(32'hA3, 1'b0);
    send_beat(32'hA4, 1'b0);
    bus.start = 1'b1;
    bus.base_vec = '1;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (bus.m_valid !== 1'b1 || bus.s_ready !== 1'b0 || bus.m_data !== e || bus.m_lanes !== 3'd4)
        begin fails++; $display("FAIL bp_hold[%0d]: got %b %b %h/%0d expected 1 0 %h/4", i, bus.m_valid, bus.s_ready, bus.m_data, bus.m_lanes, e); end
    end
    bus.start = 1'b0;
    take_out();
    tests++;
    if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin fails++; $display("FAIL bp_release: busy %b m_valid %b expected 0 0", bus.busy, bus.m_valid); end
    start_pack('0);
    tests++;
    if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL bp_restart: s_ready got %b expected 1", bus.s_ready); end
    flush_only();
    take_out();
  endtask
  task automatic test_input_gaps();
    logic [127:0] base, exp;
    logic [31:0] d;
    int n;
    bit mode;
    for (int p = 0; p < 100; p++) begin
      base = {$urandom, $urandom, $urandom, $urandom};
      n = $urandom_range(0, 4);
      mode = 1'($urandom_range(0, 1));
      exp = base;
      start_pack(base);
      for (int b = 0; b < n; b++) begin
        repeat ($urandom_range(0, 3)) step();
        d = $urandom;
        send_beat(d, (b == n - 1) && (n < 4) && mode);
        exp[b*32 +: 32] = d;
      end
      if (n < 4 && !(n > 0 && mode)) begin
        repeat ($urandom_range(0, 2)) step();
        flush_only();
      end
      tests++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== exp || bus.m_lanes !== 3'(n))
        begin fails++; $display("FAIL gaps[%0d]: got %b %h/%0d expected 1 %h/%0d", p, bus.m_valid, bus.m_data, bus.m_lanes, exp, n); end
      repeat ($urandom_range(0, 2)) step();
      take_out();
      tests++;
      if (bus.busy !== 1'b0) begin fails++; $display("FAIL gaps_idle[%0d]: busy got %b expected 0", p, bus.busy); end
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.base_vec = '0;
    bus.flush = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b0;
    test_reset();
    test_full_pack();
    test_early_flush();
    test_flush_with_beat();
    test_backpressure();
    test_input_gaps();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
